// File: rtl/leaf_out_arbiter.sv
// leaf_out_arbiter: round-robin burst arbiter, NUM_REQ req_data/req_vld/req_ack streams -> registered out_data/out_vld/out_ack, grant_vld/grant_idx show holder; clk_user, sync active-high reset
module leaf_out_arbiter #(
  parameter int PAYLOAD_BITS = 32,
  parameter int NUM_REQ = 4,
  parameter int NUM_REQ_BITS = 2,
  parameter int MAX_BURST = 8,
  parameter int BURST_BITS = 3
) (
  input  logic                            clk_user,
  input  logic                            reset,
  input  logic [NUM_REQ*PAYLOAD_BITS-1:0] req_data,
  input  logic [NUM_REQ-1:0]              req_vld,
  output logic [NUM_REQ-1:0]              req_ack,
  output logic [PAYLOAD_BITS-1:0]         out_data,
  output logic                            out_vld,
  input  logic                            out_ack,
  output logic                            grant_vld,
  output logic [NUM_REQ_BITS-1:0]         grant_idx
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_n;
  logic [NUM_REQ_BITS-1:0] g, g_n, rr_ptr, rr_ptr_n, pick, g_inc;
  logic [BURST_BITS-1:0] cnt, cnt_n;
  logic [PAYLOAD_BITS-1:0] sel;
  logic can_load, xfer, last, vld_g;
  assign can_load = !out_vld || out_ack;
  assign xfer = |req_ack;
  assign last = cnt == BURST_BITS'(MAX_BURST - 1);
  assign g_inc = (int'(g) == NUM_REQ - 1) ? '0 : g + 1'b1;
  assign grant_vld = state == BUSY;
  assign grant_idx = g;
  always_comb begin
    sel = '0;
    vld_g = 1'b0;
    req_ack = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (int'(g) == i) begin
        sel = req_data[i*PAYLOAD_BITS +: PAYLOAD_BITS];
        vld_g = req_vld[i];
      end
      req_ack[i] = (state == BUSY) && (int'(g) == i) && req_vld[i] && can_load;
    end
  end
  always_comb begin
    pick = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      for (int i = 0; i < NUM_REQ; i++)
        if (req_vld[i] && i == (int'(rr_ptr) + k) % NUM_REQ) pick = NUM_REQ_BITS'(i);
  end
  always_comb begin
    state_n = state;
    g_n = g;
    cnt_n = cnt;
    rr_ptr_n = rr_ptr;
    if (state == IDLE) begin
      if (|req_vld) begin
        state_n = BUSY;
        g_n = pick;
        cnt_n = '0;
      end
    end else if (!vld_g) begin
      state_n = IDLE;
      rr_ptr_n = g_inc;
    end else if (xfer) begin
      cnt_n = cnt + 1'b1;
      if (last) begin
        state_n = IDLE;
        rr_ptr_n = g_inc;
      end
    end
  end
  always_ff @(posedge clk_user) begin
    if (reset) begin
      state <= IDLE;
      g <= '0;
      cnt <= '0;
      rr_ptr <= '0;
      out_vld <= 1'b0;
      out_data <= '0;
    end else begin
      state <= state_n;
      g <= g_n;
      cnt <= cnt_n;
      rr_ptr <= rr_ptr_n;
      if (xfer) begin
        out_vld <= 1'b1;
        out_data <= sel;
      end else if (out_ack) out_vld <= 1'b0;
    end
  end
endmodule

// File: tb/tb_leaf_out_arbiter.sv
// tb_leaf_out_arbiter: randomized and directed checks of leaf_out_arbiter (4 req x burst 8, 3 req x burst 1) against a behavioural model
module tb_leaf_out_arbiter;
  localparam int PB = 32;
  logic clk_user = 1'b0;
  logic reset = 1'b1;
  logic [4*PB-1:0] data_a;
  logic [3:0] vld_a, ack_a;
  logic [PB-1:0] od_a;
  logic ov_a, oack_a, gv_a;
  logic [1:0] gi_a;
  logic [3*PB-1:0] data_b;
  logic [2:0] vld_b, ack_b;
  logic [PB-1:0] od_b;
  logic ov_b, oack_b, gv_b;
  logic [1:0] gi_b;
  int nr[2] = '{4, 3};
  int mb[2] = '{8, 1};
  bit v[2][4];
  logic [31:0] dat[2][4];
  bit oack[2];
  int seq[2][4];
  int budget[2][4];
  bit m_busy[2], m_ov[2];
  int m_g[2], m_cnt[2], m_ptr[2];
  int m_ack[2] = '{-1, -1};
  logic [31:0] m_od[2];
  int p_vld = 0, p_ack = 100;
  bit [3:0] en = 4'hF;
  bit rst_req = 1'b1, clear_all = 1'b0;
  int n_chk = 0, n_fail = 0;
  int nx_a = 0;
  bit pgv_a = 0, pgv_b = 0;
  int gq_a[$], gq_b[$];
  leaf_out_arbiter dut_a (
    .clk_user(clk_user), .reset(reset), .req_data(data_a), .req_vld(vld_a), .req_ack(ack_a),
    .out_data(od_a), .out_vld(ov_a), .out_ack(oack_a), .grant_vld(gv_a), .grant_idx(gi_a)
  );
  leaf_out_arbiter #(.NUM_REQ(3), .NUM_REQ_BITS(2), .MAX_BURST(1), .BURST_BITS(1)) dut_b (
    .clk_user(clk_user), .reset(reset), .req_data(data_b), .req_vld(vld_b), .req_ack(ack_b),
    .out_data(od_b), .out_vld(ov_b), .out_ack(oack_b), .grant_vld(gv_b), .grant_idx(gi_b)
  );
  always #5 clk_user = ~clk_user;
  task automatic check(string tag, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic drive_inputs();
    reset = rst_req;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < nr[d]; i++) begin
        if (m_ack[d] == i) begin
          seq[d][i]++;
          dat[d][i] = {4'(d), 4'(i), 24'(seq[d][i])};
          if (budget[d][i] > 0) budget[d][i]--;
          v[d][i] = en[i] && budget[d][i] != 0 && $urandom_range(99) < p_vld;
        end else if (!v[d][i]) v[d][i] = en[i] && budget[d][i] != 0 && $urandom_range(99) < p_vld;
        if (clear_all) v[d][i] = 1'b0;
      end
      oack[d] = $urandom_range(99) < p_ack;
    end
    for (int i = 0; i < 4; i++) begin
      vld_a[i] = v[0][i];
      data_a[i*PB +: PB] = dat[0][i];
    end
    for (int i = 0; i < 3; i++) begin
      vld_b[i] = v[1][i];
      data_b[i*PB +: PB] = dat[1][i];
    end
    oack_a = oack[0];
    oack_b = oack[1];
  endtask
  task automatic model_check(int d);
    logic [3:0] ae;
    ae = '0;
    m_ack[d] = -1;
    if (m_busy[d] && v[d][m_g[d]] && (!m_ov[d] || oack[d])) begin
      m_ack[d] = m_g[d];
      ae[m_g[d]] = 1'b1;
    end
    if (d == 0) begin
      check("a.req_ack", ack_a, ae);
      check("a.grant_vld", gv_a, m_busy[0]);
      check("a.grant_idx", gi_a, m_g[0]);
      check("a.out_vld", ov_a, m_ov[0]);
      check("a.out_data", od_a, m_od[0]);
    end else begin
      check("b.req_ack", ack_b, ae);
      check("b.grant_vld", gv_b, m_busy[1]);
      check("b.grant_idx", gi_b, m_g[1]);
      check("b.out_vld", ov_b, m_ov[1]);
      check("b.out_data", od_b, m_od[1]);
    end
  endtask
  task automatic model_edge(int d);
    bit found;
    if (reset) begin
      m_busy[d] = 0;
      m_ov[d] = 0;
      m_od[d] = '0;
      m_g[d] = 0;
      m_cnt[d] = 0;
      m_ptr[d] = 0;
      return;
    end
    if (m_ack[d] >= 0) begin
      m_ov[d] = 1;
      m_od[d] = dat[d][m_g[d]];
    end else if (oack[d]) m_ov[d] = 0;
    if (!m_busy[d]) begin
      found = 0;
      for (int k = 0; k < nr[d]; k++)
        if (!found && v[d][(m_ptr[d] + k) % nr[d]]) begin
          found = 1;
          m_g[d] = (m_ptr[d] + k) % nr[d];
          m_busy[d] = 1;
          m_cnt[d] = 0;
        end
    end else if (!v[d][m_g[d]]) begin
      m_busy[d] = 0;
      m_ptr[d] = (m_g[d] + 1) % nr[d];
    end else if (m_ack[d] >= 0) begin
      m_cnt[d]++;
      if (m_cnt[d] == mb[d]) begin
        m_busy[d] = 0;
        m_ptr[d] = (m_g[d] + 1) % nr[d];
      end
    end
  endtask
  task automatic step(int n);
    repeat (n) begin
      @(negedge clk_user);
      drive_inputs();
      #1;
      model_check(0);
      model_check(1);
      if (ack_a != 0) nx_a++;
      if (gv_a && !pgv_a) gq_a.push_back(int'(gi_a));
      if (gv_b && !pgv_b) gq_b.push_back(int'(gi_b));
      pgv_a = gv_a;
      pgv_b = gv_b;
      model_edge(0);
      model_edge(1);
    end
  endtask
  task automatic restart();
    rst_req = 1;
    clear_all = 1;
    step(2);
    rst_req = 0;
    clear_all = 0;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 4; i++) budget[d][i] = -1;
    nx_a = 0;
    gq_a.delete();
    gq_b.delete();
  endtask
  initial begin
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 4; i++) dat[d][i] = {4'(d), 4'(i), 24'h0};
    drive_inputs();
    restart();
    en = 4'b0100;
    p_vld = 100;
    p_ack = 100;
    step(19);
    check("single.words", nx_a, 16);
    check("single.grants", gq_a.size(), 2);
    restart();
    en = 4'hF;
    step(37);
    check("all.words", nx_a, 32);
    step(1);
    check("all.ngrant", gq_a.size(), 5);
    for (int i = 0; i < 5 && i < gq_a.size(); i++) check("all.order", gq_a[i], i % 4);
    for (int i = 0; i < 4 && i < gq_b.size(); i++) check("np2.order", gq_b[i], i % 3);
    foreach (gq_b[i]) check("np2.range", gq_b[i] < 3, 1);
    nx_a = 0;
    p_ack = 0;
    step(5);
    check("bp.words", nx_a <= 1, 1);
    p_ack = 100;
    step(10);
    restart();
    en = 4'b1001;
    budget[0][0] = 3;
    budget[1][0] = 3;
    step(15);
    check("early.ngrant", gq_a.size() >= 2, 1);
    if (gq_a.size() >= 2) begin
      check("early.first", gq_a[0], 0);
      check("early.second", gq_a[1], 3);
    end
    restart();
    en = 4'hF;
    repeat (6) begin
      p_vld = $urandom_range(100, 30);
      p_ack = $urandom_range(100, 20);
      step(60);
    end
    p_vld = 100;
    p_ack = 50;
    for (int i = 0; i < 50 && !(m_ov[0] && m_busy[0]); i++) step(1);
    rst_req = 1;
    step(1);
    rst_req = 0;
    step(30);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/leaf_out_arbiter.md
# leaf_out_arbiter

Round-robin arbiter that shares one leaf interface output port among several user-side output streams. It sits in the `clk_user` domain between HLS operator outputs (payload plus `ap_vld`/`ap_ack`) and the leaf interface's `din_leaf_user2interface` / `vld_user2interface` / `ack_interface2user` triple. Each granted requester can send a bounded burst of words, so no requester can starve the others. Output is registered, so the interface sees a clean single-stage source.

## Interface
Parameters:
- `PAYLOAD_BITS`, default 32: width of each data word.
- `NUM_REQ`, default 4: number of requester streams, minimum 2.
- `NUM_REQ_BITS`, default 2: width of the grant index, equal to clog2(`NUM_REQ`).
- `MAX_BURST`, default 8: maximum number of words accepted per grant, minimum 1.
- `BURST_BITS`, default 3: width of the burst counter, equal to clog2(`MAX_BURST`), minimum 1.

Ports:
- `clk_user` input 1: the only clock.
- `reset` input 1: synchronous, active-high.
- `req_data` input `NUM_REQ*PAYLOAD_BITS`: requester payloads; requester i occupies bits [i*PAYLOAD_BITS +: PAYLOAD_BITS].
- `req_vld` input `NUM_REQ`: per-requester valid (`ap_vld`).
- `req_ack` output `NUM_REQ`: per-requester accept (`ap_ack`).
- `out_data` output `PAYLOAD_BITS`: registered word to the interface.
- `out_vld` output 1: registered valid to the interface.
- `out_ack` input 1: accept from the interface.
- `grant_vld` output 1: a grant is currently held.
- `grant_idx` output `NUM_REQ_BITS`: index of the current grant holder; meaningful only when `grant_vld` is 1.

## Operation
- A transfer on either side happens in any cycle where vld and ack are both 1 on the rising edge of `clk_user`.
- Output register:
  - `can_load = !out_vld || out_ack`.
  - On an input transfer, the register loads `req_data[g]` and sets `out_vld`.
  - Otherwise, if `out_ack` is 1, `out_vld` clears.
  - `out_data` holds its value when not loading.
- `req_ack[i] = (state==BUSY) && (g==i) && req_vld[i] && can_load`. This is combinational, and at most one bit is ever set.
- State machine, states IDLE and BUSY:
  - IDLE: if any `req_vld` is set, register `g` as the first set index searching upward from `rr_ptr` with wrap-around, clear `cnt`, and go to BUSY. No transfer occurs in IDLE.
  - BUSY with `req_vld[g]`=1 and `req_ack[g]`=1: increment `cnt`. If `cnt==MAX_BURST-1`, go to IDLE and set `rr_ptr=(g+1) mod NUM_REQ`.
  - BUSY with `req_vld[g]`=0: release the grant, go to IDLE, and set `rr_ptr=(g+1) mod NUM_REQ`. No transfer occurs this cycle.
  - BUSY with `req_vld[g]`=1 and `can_load`=0: hold the grant; `cnt` is unchanged.
- `grant_vld` is 1 exactly in BUSY. `grant_idx` is `g`.
- `rr_ptr` wraps modulo `NUM_REQ`; this must be correct for non-power-of-2 `NUM_REQ`.
- A requester must hold `req_vld` and `req_data` until it is acked. This is the HLS contract; the arbiter does not check it.

## Timing
- Reset values:
  - `out_vld`=0, `out_data`=0.
  - state=IDLE, so `grant_vld`=0 and `grant_idx`=0.
  - `rr_ptr`=0, `cnt`=0.
  - `req_ack`=0, which follows from state=IDLE.
- Reset mid-burst: the word in the output register is dropped and the grant is lost; the leaf interface resend mechanism recovers it. Reset takes priority over all other updates.
- Arbitration costs 1 cycle: `req_vld` rises in cycle t, `grant_vld` is 1 in t+1, and the earliest `req_ack` is in t+1.
- Latency: a word acked in cycle t appears on `out_vld`/`out_data` in t+1.
- Throughput with `out_ack` held at 1 and all requesters valid: `MAX_BURST` words per `MAX_BURST`+1 cycles.
- Simultaneous load and drain (`out_vld`=1, `out_ack`=1, input transfer in the same cycle): the register reloads and `out_vld` stays 1. Full rate is sustained with no bubble.
- With `out_ack` held at 0, at most one word is accepted, then `req_ack` stays 0 and the grant is held. `cnt` does not advance, so no words are lost or duplicated.
- `MAX_BURST`=1: every grant releases after one word.

## Test plan
- Single requester: reset, then `req_vld[2]`=1 with data 0x100..0x10F, `out_ack`=1. Expect grant_idx=2, 16 words emitted in order, and a 1-cycle IDLE gap after every 8 words. `rr_ptr` returns to 3, then the search wraps to 2.
- All four requesters continuously valid, `MAX_BURST`=8, `out_ack`=1. Expect grant order 0,1,2,3,0; 8 words each; 32 words in 36 cycles.
- Backpressure: grant held by requester 1, `out_ack`=0 for 5 cycles. Expect exactly one word accepted, `out_data` stable, `cnt` frozen. When `out_ack` returns to 1, the stream resumes with no loss or duplication.
- Early release: requester 0 sends 3 words then drops `req_vld`; requester 3 is valid. Expect release, IDLE for 1 cycle, then grant to 3, skipping 1 and 2 because they are not valid.
- Reset mid-burst: assert `reset` for 1 cycle with `out_vld`=1. Expect `out_vld`=0, `grant_vld`=0 and `rr_ptr`=0 next cycle; the first grant after reset goes to the lowest valid index.
- Non-power-of-2 case, `NUM_REQ`=3 with all requesters valid. Expect grants 0,1,2,0 and never index 3.
